// File: rtl/sqrt_pkg.sv
// sqrt_pkg: handshake state encoding shared by the square-root responders.
package sqrt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sqrt_state_t;
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational digit-by-digit square-root step, consuming one bit pair
// of the radicand and producing one root bit.
module isqrt_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH/2+1:0] rem_in,
    input  logic [WIDTH/2-1:0] root_in,
    input  logic [1:0]         pair_in,
    output logic [WIDTH/2+1:0] rem_out,
    output logic [WIDTH/2-1:0] root_out
);
    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;
    logic [RW+1:0] cat;
    logic [RW+1:0] sub;
    logic          ge;
    // Compare instead of inspecting a borrow bit; the kept remainder always fits in RW bits.
    always_comb begin
        cat      = {rem_in, pair_in};
        sub      = {2'b00, root_in, 2'b01};
        ge       = cat >= sub;
        rem_out  = ge ? RW'(cat - sub) : RW'(cat);
        root_out = HW'({root_in, ge});
    end
endmodule

// File: rtl/isqrt_digit_unit.sv
// isqrt_digit_unit: iterative floor(sqrt(x)) and remainder, one root bit per cycle,
// single request in flight over a start/done handshake.
module isqrt_digit_unit
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   root,
    output logic [WIDTH/2:0]   remainder
);
    localparam int HW    = WIDTH / 2;
    localparam int RW    = HW + 2;
    localparam int ITERS = WIDTH / 2;
    localparam int IW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    sqrt_state_t       state_q, state_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [WIDTH-1:0]  x_sh_q, x_sh_d;
    logic [RW-1:0]     rem_acc_q, rem_acc_d;
    logic [HW-1:0]     root_acc_q, root_acc_d;
    logic [WIDTH-1:0]  root_q, root_d;
    logic [HW:0]       rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RW-1:0]     step_rem;
    logic [HW-1:0]     step_root;
    logic              last;

    isqrt_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_acc_q),
        .root_in (root_acc_q),
        .pair_in (x_sh_q[WIDTH-1:WIDTH-2]),
        .rem_out (step_rem),
        .root_out(step_root)
    );

    assign last = iter_q == IW'(ITERS - 1);

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        x_sh_d     = x_sh_q;
        rem_acc_d  = rem_acc_q;
        root_acc_d = root_acc_q;
        root_d     = root_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d    = RUN;
                x_sh_d     = x;
                rem_acc_d  = '0;
                root_acc_d = '0;
                iter_d     = '0;
                busy_d     = 1'b1;
            end
            RUN: begin
                x_sh_d     = {x_sh_q[WIDTH-3:0], 2'b00};
                rem_acc_d  = step_rem;
                root_acc_d = step_root;
                iter_d     = last ? '0 : iter_q + 1'b1;
                // Outputs are only touched on the final step so they never change mid-run.
                if (last) begin
                    state_d = DONE;
                    root_d  = {{(WIDTH-HW){1'b0}}, step_root};
                    rem_d   = (HW+1)'(step_rem);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            x_sh_q     <= '0;
            rem_acc_q  <= '0;
            root_acc_q <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            x_sh_q     <= x_sh_d;
            rem_acc_q  <= rem_acc_d;
            root_acc_q <= root_acc_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign root      = root_q;
    assign remainder = rem_q;
endmodule

// File: tb/tb_isqrt_digit_unit.sv
// tb_isqrt_digit_unit: scoreboard bench for the iterative square-root responder.
module tb_isqrt_digit_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] root;
    logic [16:0] remainder;

    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        logic [16:0] m;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;
    int          cyc = 0;
    logic        done_prev = 1'b0;
    logic [31:0] got_root = '0;
    logic [16:0] got_rem = '0;

    isqrt_digit_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(busy), .done(done), .root(root), .remainder(remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        logic [63:0] lo, hi, mid;
        exp_t e;
        lo = 0;
        hi = 64'd65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= {32'd0, v}) lo = mid;
            else hi = mid;
        end
        e.x = v;
        e.r = lo[31:0];
        e.m = 17'({32'd0, v} - lo * lo);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            logic [63:0] rr;
            chk("done_pulse", {63'd0, done_prev}, 64'd0);
            n_done++;
            got_root = root;
            got_rem = remainder;
            if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                rr = {32'd0, root};
                chk("root", {32'd0, root}, {32'd0, e.r});
                chk("rem", {47'd0, remainder}, {47'd0, e.m});
                chk("bound", {63'd0, (rr * rr <= {32'd0, e.x}) && ((rr + 1) * (rr + 1) > {32'd0, e.x})}, 64'd1);
            end
        end
        done_prev = done;
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || done) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy || done) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic req(input logic [31:0] v, output int lat);
        wait_idle();
        start = 1'b1;
        x = v;
        sb.push_back(model(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        x = $urandom;
        chk("busy_acc", {63'd0, busy}, 64'd1);
        wait_done(lat);
    endtask

    task automatic run_chk(input logic [31:0] v, input logic [31:0] er, input logic [16:0] em);
        int lat;
        req(v, lat);
        @(negedge clk);
        #1;
        chk("c_root", {32'd0, got_root}, {32'd0, er});
        chk("c_rem", {47'd0, got_rem}, {47'd0, em});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n0, t1, t2, t3, k;
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_root", {32'd0, root}, 64'd0);
        chk("rst_rem", {47'd0, remainder}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        req(32'd16, lat);
        chk("latency", 64'(lat), 64'd16);
        @(negedge clk);
        #1;
        chk("c_root", {32'd0, got_root}, 64'd4);
        chk("c_rem", {47'd0, got_rem}, 64'd0);
        run_chk(32'd17, 32'd4, 17'd1);
        run_chk(32'd2, 32'd1, 17'd1);
        run_chk(32'd0, 32'd0, 17'd0);
        run_chk(32'hFFFF_FFFF, 32'd65535, 17'd131070);
        run_chk(32'hFFFE_0001, 32'd65535, 17'd0);

        n0 = n_done;
        wait_idle();
        start = 1'b1;
        x = 32'd100;
        sb.push_back(model(32'd100));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        x = 32'd49;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("ign_root", {32'd0, got_root}, 64'd10);
        chk("ign_count", 64'(n_done - n0), 64'd1);

        n0 = n_done;
        wait_idle();
        start = 1'b1;
        x = 32'h1234_5678;
        repeat (3) sb.push_back(model(32'h1234_5678));
        t1 = 0; t2 = 0; t3 = 0; k = 0;
        while (t3 == 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (t1 == 0) t1 = cyc;
                else if (t2 == 0) t2 = cyc;
                else begin
                    t3 = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("period1", 64'(t2 - t1), 64'd18);
        chk("period2", 64'(t3 - t2), 64'd18);
        chk("held_count", 64'(n_done - n0), 64'd3);

        n0 = n_done;
        wait_idle();
        start = 1'b1;
        x = 32'd1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_root", {32'd0, root}, 64'd0);
        chk("abort_rem", {47'd0, remainder}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_nodone", 64'(n_done - n0), 64'd0);
        run_chk(32'd81, 32'd9, 17'd0);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] v;
            v = $urandom >> $urandom_range(0, 31);
            req(v, lat);
        end
        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
